// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: funct3 decode, sequencer state encoding and result constants.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } m_func;

  typedef logic [1:0] muldiv_state_e;

  localparam muldiv_state_e ST_IDLE = 2'd0;
  localparam muldiv_state_e ST_MUL  = 2'd1;
  localparam muldiv_state_e ST_DIV  = 2'd2;
  localparam muldiv_state_e ST_DONE = 2'd3;

  localparam logic [XLEN-1:0] DIV0_Q  = '1;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on unsigned magnitudes: shifts the next dividend bit in.
module div_step
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // The difference always fits in XLEN bits whenever the subtraction is taken.
  assign shifted = {rem_in, quo_in[XLEN-1]};
  assign fits    = shifted >= {1'b0, divisor};
  assign diff    = shifted[XLEN-1:0] - divisor;
  assign rem_out = fits ? diff : shifted[XLEN-1:0];
  assign quo_out = {quo_in[XLEN-2:0], fits};

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer with a one-deep response register.
// MULDIV_FASTPATH_EN: divide-by-zero and signed overflow skip the iterations.
module muldiv_seq
  import riscv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_func,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [4:0]      req_rd,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_rd,
  output logic            busy
);

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LAST = 5'(XLEN - 1);

  muldiv_state_e   state_q, state_d;
  logic [4:0]      cnt_q;
  m_func           func_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic [XLEN-1:0] rem_nx, quo_nx;
  logic            accept, fast_c;

  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign busy      = (state_q != ST_IDLE);
  assign accept    = req_valid && req_ready;

`ifdef MULDIV_FASTPATH_EN
  assign fast_c = req_func[2] && ((req_rs2 == '0) ||
                  (!req_func[0] && (req_rs1 == INT_MIN) && (req_rs2 == '1)));
`else
  assign fast_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state; flush overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = fast_c ? ST_DONE : (req_func[2] ? ST_DIV : ST_MUL);
      ST_MUL:  if (cnt_q == MUL_LAST) state_d = ST_DONE;
      ST_DIV:  if (cnt_q == DIV_LAST) state_d = ST_DONE;
      ST_DONE: if (rsp_valid && rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  div_step u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvsr_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Multiply: operand extension chosen by funct3.
  logic              s1_c, s2_c;
  logic [2*XLEN-1:0] op1_c, op2_c, prod_c;
  logic [XLEN-1:0]   mul_res_c;

  assign s1_c      = (func_q != MULHU);
  assign s2_c      = (func_q == MUL) || (func_q == MULH);
  assign op1_c     = {{XLEN{s1_c & rs1_q[XLEN-1]}}, rs1_q};
  assign op2_c     = {{XLEN{s2_c & rs2_q[XLEN-1]}}, rs2_q};
  assign prod_c    = op1_c * op2_c;
  assign mul_res_c = (func_q == MUL) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];

  // Divide sign fixup and RISC-V corner-case results.
  logic            sgn_c, neg1_c, neg2_c;
  logic [XLEN-1:0] q_fix_c, r_fix_c, div_res_c;

  assign sgn_c  = !func_q[0];
  assign neg1_c = sgn_c && rs1_q[XLEN-1];
  assign neg2_c = sgn_c && rs2_q[XLEN-1];

  always_comb begin
    q_fix_c = (neg1_c ^ neg2_c) ? -quo_q : quo_q;
    r_fix_c = neg1_c ? -rem_q : rem_q;
    if (rs2_q == '0) begin
      q_fix_c = DIV0_Q;
      r_fix_c = rs1_q;
    end else if (sgn_c && (rs1_q == INT_MIN) && (rs2_q == '1)) begin
      q_fix_c = INT_MIN;
      r_fix_c = '0;
    end
  end

  assign div_res_c = func_q[1] ? r_fix_c : q_fix_c;

  // Operand capture, iteration and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      func_q    <= MUL;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
    end else begin
      if (accept) begin
        func_q <= m_func'(req_func);
        rs1_q  <= req_rs1;
        rs2_q  <= req_rs2;
        rd_q   <= req_rd;
        cnt_q  <= '0;
        rem_q  <= '0;
        quo_q  <= (!req_func[0] && req_rs1[XLEN-1]) ? -req_rs1 : req_rs1;
        dvsr_q <= (!req_func[0] && req_rs2[XLEN-1]) ? -req_rs2 : req_rs2;
      end else if ((state_q == ST_MUL) || (state_q == ST_DIV)) begin
        cnt_q <= cnt_q + 5'd1;
      end
      if (state_q == ST_DIV) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
      end
      if (flush) begin
        rsp_valid <= 1'b0;
      end else if ((state_q == ST_MUL) && (state_d == ST_DONE)) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mul_res_c;
        rsp_rd    <= rd_q;
      end else if ((state_q == ST_DONE) && !rsp_valid) begin
        rsp_valid <= 1'b1;
        rsp_data  <= div_res_c;
        rsp_rd    <= rd_q;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, flush/reset sequences, randomized ops vs a reference model.
module tb_muldiv_seq;
  import riscv_pkg::*;

  localparam int unsigned MC = 2;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, flush, rsp_valid, rsp_ready, busy;
  logic [2:0]  req_func;
  logic [31:0] req_rs1, req_rs2, rsp_data;
  logic [4:0]  req_rd, rsp_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference results straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, p;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(int'(a) / int'(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(int'(a) % int'(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return int'(MC);
`ifdef MULDIV_FASTPATH_EN
    if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 33;
  endfunction

  // Issue one op, check latency/result/tag, hold rsp_ready low for 'hold' cycles, then drain.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int hold);
    int k;
    logic [31:0] d0;
    logic [4:0]  r0;
    k = 0;
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_func = f; req_rs1 = a; req_rs2 = b; req_rd = rd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
    chk({nm, "_latency"}, 32'(k), 32'(exp_lat(f, a, b)));
    if (!rsp_valid) return;
    chk({nm, "_data"}, rsp_data, exp);
    chk({nm, "_rd"}, 32'(rsp_rd), 32'(rd));
    d0 = rsp_data; r0 = rsp_rd;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, "_hold_data"}, rsp_data, d0);
      chk({nm, "_hold_rd"}, 32'(rsp_rd), 32'(r0));
      chk({nm, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      chk({nm, "_hold_busy"}, 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, "_drain_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_drain_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic no_rsp(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 0};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 1};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFEC,  32'd3,         5'd7,  32'hFFFF_FFFA, 0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFEC,  32'd3,         5'd8,  32'hFFFF_FFFE, 5};
    vecs[6]  = '{3'd5, 32'h1234,       32'd0,         5'd9,  32'hFFFF_FFFF, 0};
    vecs[7]  = '{3'd7, 32'h1234,       32'd0,         5'd10, 32'h0000_1234, 0};
    vecs[8]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0};
    vecs[9]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 2};
    vecs[10] = '{3'd4, 32'h1234,       32'd0,         5'd13, 32'hFFFF_FFFF, 0};
    vecs[11] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         5'd14, 32'hFFFF_FFFB, 0};
    vecs[12] = '{3'd5, 32'd100,        32'd7,         5'd15, 32'd14,        0};
    vecs[13] = '{3'd7, 32'd100,        32'd7,         5'd16, 32'd2,         0};
    vecs[14] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 5'd31, 32'hFFFF_FFFD, 1};

    reset = 1'b1; req_valid = 1'b0; req_func = 3'd0; req_rs1 = '0; req_rs2 = '0;
    req_rd = '0; flush = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, vecs[i].hold);

    // Flush a divide around iteration 10.
    req_valid = 1'b1; req_func = 3'd4; req_rs1 = 32'd1000; req_rs2 = 32'd7; req_rd = 5'd20;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_pre_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    #1 chk("flush_req_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_req_ready", 32'(req_ready), 32'd1);
    no_rsp("flush_no_rsp", 40);
    run_op("post_flush_mul", 3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 0);

    // Reset in the middle of a divide.
    req_valid = 1'b1; req_func = 3'd5; req_rs1 = 32'd999; req_rs2 = 32'd5; req_rd = 5'd22;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_rsp_rd", 32'(rsp_rd), 32'd0);
    no_rsp("midrst_no_rsp", 40);

    // Randomized ops, with a bias toward the divide corner cases.
    for (int n = 0; n < 150; n++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op($sformatf("rnd%0d", n), f, a, b, rd, ref_model(f, a, b), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
